bg_vram_port: RTL and testbench
===============================

Name: bg_vram_port

Overview:
- Background frame store serving the VGA background read port consumed by the color mapper.
- Holds 320x240 4-bit palette indices packed two per byte (high nibble = even pixel), 38400 bytes.
- Returns `vga_port_backgrounddata` for a given `vga_port_local_addr`.
- Accepts host byte writes through a valid/ready write queue, and has a hardware fill engine for clearing or flooding the whole screen.

Parameters:
- DEPTH, 38400, number of bytes stored; valid addresses 0..DEPTH-1.
- ADDR_W, 16, address width of both read and write ports.
- FIFO_DEPTH, 4, host write queue entries (power of two).

Ports:
- VGA_Clk  in  1  single clock for all logic.
- Reset  in  1  asynchronous, active-high reset.
- vga_port_local_addr  in  16  byte address requested by the VGA side.
- vga_port_backgrounddata  out  8  byte at the address presented in the previous cycle.
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  queue can accept a write this cycle.
- host_wr_addr  in  16  host write byte address.
- host_wr_data  in  8  host write byte (two packed palette indices).
- fill_start  in  1  one-cycle request to fill the whole store.
- fill_data  in  8  byte used by the fill; sampled on the accepted fill_start.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse when the fill completes.
- addr_err  out  1  sticky flag: a host write with out-of-range address was dropped.

Behaviour:
- Reset: asynchronous and active-high. While Reset is high, all outputs are 0: data, ready, busy, done, err.
  - After release: host_wr_ready=1, fill engine IDLE, queue empty.
  - Memory contents are not cleared by reset.
- Storage: simple dual-port RAM.
  - Read port is dedicated to VGA.
  - Write port is shared by the fill engine and the queue drain.
- Read path:
  - Registered output, latency exactly 1 cycle: data at edge N+1 = mem[addr sampled at edge N].
  - addr >= DEPTH returns 0x00.
  - A read and a write to the same address in the same cycle returns the OLD byte (read-before-write).
- Host write queue:
  - A write is accepted on a cycle with host_wr_valid & host_wr_ready.
  - host_wr_ready = !queue_full, registered-equivalent (no combinational path from valid).
  - Push and pop in the same cycle are allowed when the queue is non-empty. Occupancy is unchanged.
  - Drain: one entry per cycle, only while the fill FSM is IDLE and not starting. The fill has priority on the write port.
  - Entries keep FIFO order. Writes accepted during a fill land after the fill completes, overwriting the filled bytes.
  - Entry with addr >= DEPTH: popped and discarded, and addr_err is set. addr_err clears only on Reset.
- Fill FSM, states IDLE, FILL, DONE:
  - IDLE -> FILL on fill_start: latch fill_data, counter = 0, fill_busy=1 from the next cycle.
  - FILL: write latched byte to mem[counter], counter++. After writing DEPTH-1 -> DONE. Exactly DEPTH write cycles.
  - DONE: fill_done=1 for one cycle, fill_busy=0, -> IDLE.
  - fill_start in FILL or DONE is ignored; no queueing of fill requests.
  - fill_start in the same cycle as a pending queue drain: the fill wins that cycle, and the drain resumes after DONE.
  - Reset mid-fill aborts the fill. Already-written bytes remain, no fill_done pulse.
- Arithmetic: counter is ADDR_W bits and never wraps, since it terminates at DEPTH-1. Queue pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: BG_VRAM_READ_BLANK_EN.
- Defined:
  - While fill_busy=1, vga_port_backgrounddata is forced to the latched fill byte, still with 1-cycle latency.
  - This hides tearing during a clear.
  - fill_busy is sampled in the same cycle as the address.
- Undefined: reads always return RAM contents, and partially filled frames are visible.

Test Plan:
- Reset then read: after reset, write 0xA5 to addr 100, read addr 100 -> data 0xA5 exactly one cycle after the address. Read addr 40000 -> 0x00.
- Queue backpressure: hold host_wr_valid for 6 cycles while fill_busy=1 -> exactly 4 accepted, host_wr_ready=0 after the 4th. After fill_done, all 4 bytes land in order.
- Fill timing: fill_start with fill_data=0x33 -> fill_busy high for 38400 cycles, fill_done single pulse. Reads of addrs 0, 19200 and 38399 return 0x33.
- Simultaneous fill and drain: queue holds write (addr 5, 0x7E), then fill_start 0x00 -> after completion, addr 5 reads 0x7E and addr 6 reads 0x00.
- Bad address: host write to addr 38400 -> addr_err=1 sticky, no memory change. Reset -> addr_err=0.
- Reset mid-fill: assert Reset at fill cycle 1000 -> outputs 0 immediately, no fill_done. Addr 999 holds the fill byte, addr 1001 holds its prior value.

Source files
------------

// File: rtl/bg_vram_port_if.sv
// Bus bundle for the background VRAM port: VGA read port, host write
// queue handshake and fill-engine controls. The frame store itself uses
// the slave view; whoever drives it (mapper/host/bench) uses the master view.
interface bg_vram_port_if #(
  parameter int ADDR_W = 16
);
  // VGA read side
  logic [ADDR_W-1:0] vga_port_local_addr;
  logic [7:0]        vga_port_backgrounddata;

  // Host byte write queue
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [7:0]        host_wr_data;

  // Fill engine
  logic              fill_start;
  logic [7:0]        fill_data;
  logic              fill_busy;
  logic              fill_done;

  // Sticky out-of-range write indication
  logic              addr_err;

  modport master (
    output vga_port_local_addr,
    input  vga_port_backgrounddata,
    output host_wr_valid,
    input  host_wr_ready,
    output host_wr_addr,
    output host_wr_data,
    output fill_start,
    output fill_data,
    input  fill_busy,
    input  fill_done,
    input  addr_err
  );

  modport slave (
    input  vga_port_local_addr,
    output vga_port_backgrounddata,
    input  host_wr_valid,
    output host_wr_ready,
    input  host_wr_addr,
    input  host_wr_data,
    input  fill_start,
    input  fill_data,
    output fill_busy,
    output fill_done,
    output addr_err
  );
endinterface

// File: rtl/bg_vram_port.sv
// Background frame store for the VGA color mapper.
// 320x240 4-bit palette indices packed two per byte (high nibble = even
// pixel). One read port is dedicated to VGA (1-cycle registered read,
// read-before-write); the single write port is shared by a whole-screen
// fill engine (priority) and a small host write queue.
//
// Optional build macro: BG_VRAM_READ_BLANK_EN
//   defined   -> while a fill is running, reads return the fill byte so a
//                clear never shows a half-erased frame.
//   undefined -> reads always return RAM contents.
module bg_vram_port #(
  parameter int DEPTH      = 38400,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic           VGA_Clk,
  input logic           Reset,
  bg_vram_port_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  logic [7:0] mem [DEPTH];

  // ------------------------------------------------------------------
  // Fill engine state
  // ------------------------------------------------------------------
  fill_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic [7:0]        fill_byte_reg, fill_byte_next;
  logic              fill_accept;
  logic              fill_we;

  // ------------------------------------------------------------------
  // Host write queue state
  // ------------------------------------------------------------------
  logic [ADDR_W-1:0] q_addr_reg [FIFO_DEPTH];
  logic [7:0]        q_data_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ready_reg, ready_next;
  logic              err_reg, err_next;
  logic              q_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [7:0]        head_data;
  logic              head_ok;
  logic              drain_we;

  // ------------------------------------------------------------------
  // Shared write port
  // ------------------------------------------------------------------
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [7:0]        rd_raw_reg;
  logic              rd_ok_reg;
  logic [7:0]        rd_byte;

  // A fill can only be accepted from IDLE; requests in FILL/DONE are dropped.
  assign fill_accept = (state_reg == ST_IDLE) && bus.fill_start;
  assign fill_we     = (state_reg == ST_FILL);

  // Fill FSM state register; reset aborts any fill in progress.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      fill_cnt_reg  <= '0;
      fill_byte_reg <= 8'h00;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      fill_byte_reg <= fill_byte_next;
    end
  end

  // Fill FSM next state: one byte per cycle from address 0 to DEPTH-1,
  // then a single DONE cycle that produces the completion pulse.
  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    fill_byte_next = fill_byte_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.fill_start) begin
          state_next     = ST_FILL;
          fill_cnt_next  = '0;
          fill_byte_next = bus.fill_data;
        end
      end
      ST_FILL: begin
        // The counter stops at the last address instead of wrapping.
        if (fill_cnt_reg == LAST_A) begin
          state_next = ST_DONE;
        end else begin
          fill_cnt_next = fill_cnt_reg + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Queue bookkeeping. ready is a flop computed from the next occupancy,
  // so host_wr_valid never reaches host_wr_ready combinationally.
  assign q_empty   = (count_reg == '0);
  assign push      = bus.host_wr_valid && ready_reg;
  // Drain only while the fill engine is idle and not being started this
  // cycle: the fill owns the write port whenever it wants it.
  assign pop       = !q_empty && (state_reg == ST_IDLE) && !bus.fill_start;
  assign head_addr = q_addr_reg[rd_ptr_reg];
  assign head_data = q_data_reg[rd_ptr_reg];
  assign head_ok   = (head_addr < DEPTH_A);
  // Out-of-range entries are still popped, just never written.
  assign drain_we  = pop && head_ok;

  // Queue pointer, occupancy, ready and error next-state logic.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    err_next    = err_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
      if (!head_ok) begin
        err_next = 1'b1;
      end
    end
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
    ready_next = (count_next != FULL_C);
  end

  // Queue control registers; ready stays low while Reset is held.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ready_reg  <= ready_next;
      err_reg    <= err_next;
    end
  end

  // Queue payload storage; contents are don't-care until pushed.
  always_ff @(posedge VGA_Clk) begin
    if (push) begin
      q_addr_reg[wr_ptr_reg] <= bus.host_wr_addr;
      q_data_reg[wr_ptr_reg] <= bus.host_wr_data;
    end
  end

  // Write port mux: fill and drain are mutually exclusive by construction.
  assign wr_en   = fill_we || drain_we;
  assign wr_addr = fill_we ? fill_cnt_reg : head_addr;
  assign wr_data = fill_we ? fill_byte_reg : head_data;

  // RAM write port (contents are deliberately not touched by reset).
  always_ff @(posedge VGA_Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Out-of-range read addresses are clamped to a legal row and masked later.
  assign rd_ok  = (bus.vga_port_local_addr < DEPTH_A);
  assign rd_idx = rd_ok ? bus.vga_port_local_addr : '0;

  // RAM read port; a same-cycle write to this address returns the old byte.
  always_ff @(posedge VGA_Clk) begin
    rd_raw_reg <= mem[rd_idx];
  end

  // Address-valid flag travels alongside the read so the output is 0
  // during reset and for addresses beyond the frame.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      rd_ok_reg <= 1'b0;
    end else begin
      rd_ok_reg <= rd_ok;
    end
  end

  assign rd_byte = rd_ok_reg ? rd_raw_reg : 8'h00;

`ifdef BG_VRAM_READ_BLANK_EN
  logic blank_reg;

  // Busy is sampled with the address, so blanking has the same latency
  // as the read it replaces.
  always_ff @(posedge VGA_Clk or posedge Reset) begin
    if (Reset) begin
      blank_reg <= 1'b0;
    end else begin
      blank_reg <= fill_we;
    end
  end

  assign bus.vga_port_backgrounddata = blank_reg ? fill_byte_reg : rd_byte;
`else
  assign bus.vga_port_backgrounddata = rd_byte;
`endif

  // Status outputs decode registered state only.
  assign bus.host_wr_ready = ready_reg;
  assign bus.fill_busy     = (state_reg == ST_FILL);
  assign bus.fill_done     = (state_reg == ST_DONE);
  assign bus.addr_err      = err_reg;

endmodule

// File: tb/tb_bg_vram_port.sv
// Directed bench for bg_vram_port: reset, read latency, bad address,
// fill timing with queue backpressure, fill/drain priority, reset mid-fill.
`timescale 1ns/1ps
module tb_bg_vram_port;

  localparam int DEPTH = 38400;

  logic VGA_Clk = 1'b0;
  logic Reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   fill_cyc0 = 0;

  always #5 VGA_Clk = ~VGA_Clk;

  always @(posedge VGA_Clk) cyc <= cyc + 1;

  bg_vram_port_if #(.ADDR_W(16)) bus ();

  bg_vram_port #(
    .DEPTH(DEPTH),
    .ADDR_W(16),
    .FIFO_DEPTH(4)
  ) dut (
    .VGA_Clk(VGA_Clk),
    .Reset(Reset),
    .bus(bus)
  );

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge VGA_Clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    while (!bus.host_wr_ready && n < 50) begin
      step();
      n++;
    end
    if (!bus.host_wr_ready) begin
      checks++;
      errors++;
      $display("FAIL host_write_ready_timeout: ready=%0b required 1", bus.host_wr_ready);
    end
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = a;
    bus.host_wr_data  = d;
    step();
    bus.host_wr_valid = 1'b0;
    step();
    step();
    $display("host write addr=%0d data=%02h", a, d);
  endtask

  task automatic read_byte(input logic [15:0] a, output logic [7:0] d);
    bus.vga_port_local_addr = a;
    step();
    d = bus.vga_port_backgrounddata;
    $display("read addr=%0d data=%02h", a, d);
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.fill_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (bus.vga_port_backgrounddata !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h required 00", bus.vga_port_backgrounddata); end
    checks++; if (bus.host_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b required 0", bus.host_wr_ready); end
    checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", bus.fill_busy); end
    checks++; if (bus.fill_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b required 0", bus.fill_done); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b required 0", bus.addr_err); end
    Reset = 1'b0;
    step();
    checks++; if (bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b required 1", bus.host_wr_ready); end
    checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %0b required 0", bus.fill_busy); end
    $display("reset sequence complete");
  endtask

  task automatic test_read_latency();
    logic [7:0] d;
    host_write(16'd100, 8'hA5);
    host_write(16'd101, 8'h5C);
    // Back-to-back addresses: each byte must appear exactly one cycle later.
    bus.vga_port_local_addr = 16'd101;
    step();
    bus.vga_port_local_addr = 16'd100;
    checks++; if (bus.vga_port_backgrounddata !== 8'h5C) begin errors++; $display("FAIL lat_101: got %02h required 5c", bus.vga_port_backgrounddata); end
    step();
    checks++; if (bus.vga_port_backgrounddata !== 8'hA5) begin errors++; $display("FAIL lat_100: got %02h required a5", bus.vga_port_backgrounddata); end
    read_byte(16'd40000, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL read_oob_40000: got %02h required 00", d); end
  endtask

  task automatic test_bad_addr();
    logic [7:0] d;
    host_write(16'd0, 8'h12);
    host_write(16'd38400, 8'h77);
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL bad_addr_err: got %0b required 1", bus.addr_err); end
    read_byte(16'd0, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL bad_addr_mem0: got %02h required 12", d); end
    host_write(16'd300, 8'h44);
    checks++; if (bus.addr_err !== 1'b1) begin errors++; $display("FAIL bad_addr_sticky: got %0b required 1", bus.addr_err); end
    read_byte(16'd300, d);
    checks++; if (d !== 8'h44) begin errors++; $display("FAIL good_write_300: got %02h required 44", d); end
    Reset = 1'b1;
    #1;
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b required 0", bus.addr_err); end
    step();
    Reset = 1'b0;
    step();
    read_byte(16'd100, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL mem_kept_reset: got %02h required a5", d); end
  endtask

  task automatic test_fill_start();
    bus.fill_data  = 8'h33;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    bus.fill_data  = 8'hFF;
    fill_cyc0 = cyc;
    checks++; if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_start: got %0b required 1", bus.fill_busy); end
    checks++; if (bus.fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_start: got %0b required 0", bus.fill_done); end
    $display("fill started data=33");
  endtask

  task automatic test_backpressure();
    logic [15:0] ta [4] = '{16'd200, 16'd201, 16'd202, 16'd200};
    logic [7:0]  td [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int acc = 0;
    step();
    // A second fill request mid-fill must be ignored.
    bus.fill_data  = 8'hEE;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int k = (acc < 4) ? acc : 3;
      bus.host_wr_valid = 1'b1;
      bus.host_wr_addr  = ta[k];
      bus.host_wr_data  = td[k];
      if (bus.host_wr_ready) acc++;
      step();
    end
    bus.host_wr_valid = 1'b0;
    $display("backpressure accepted=%0d", acc);
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d required 4", acc); end
    checks++; if (bus.host_wr_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b required 0", bus.host_wr_ready); end
    checks++; if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b required 1", bus.fill_busy); end
  endtask

  task automatic test_fill_complete();
    logic [7:0] d;
    bit seen;
    wait_done(40000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL fill_done_timeout: done=%0b required 1", bus.fill_done); end
    checks++; if (cyc - fill_cyc0 != DEPTH) begin errors++; $display("FAIL fill_busy_len: got %0d required %0d", cyc - fill_cyc0, DEPTH); end
    checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %0b required 0", bus.fill_busy); end
    step();
    checks++; if (bus.fill_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %0b required 0", bus.fill_done); end
    repeat (6) step();
    checks++; if (bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %0b required 1", bus.host_wr_ready); end
    read_byte(16'd0, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL fill_addr0: got %02h required 33", d); end
    read_byte(16'd19200, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL fill_addr19200: got %02h required 33", d); end
    read_byte(16'd38399, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL fill_addr38399: got %02h required 33", d); end
    read_byte(16'd200, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL order_200: got %02h required 04", d); end
    read_byte(16'd201, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL order_201: got %02h required 02", d); end
    read_byte(16'd202, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL order_202: got %02h required 03", d); end
  endtask

  task automatic test_fill_vs_drain();
    logic [7:0] d;
    bit seen;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = 16'd5;
    bus.host_wr_data  = 8'h7E;
    step();
    bus.host_wr_valid = 1'b0;
    // Entry is pending; the fill takes the write port this cycle.
    bus.fill_data  = 8'h00;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    checks++; if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL fvd_busy: got %0b required 1", bus.fill_busy); end
    wait_done(40000, seen);
    checks++; if (!seen) begin errors++; $display("FAIL fvd_done_timeout: done=%0b required 1", bus.fill_done); end
    repeat (3) step();
    read_byte(16'd5, d);
    checks++; if (d !== 8'h7E) begin errors++; $display("FAIL fvd_addr5: got %02h required 7e", d); end
    read_byte(16'd6, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL fvd_addr6: got %02h required 00", d); end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    int done_seen = 0;
    host_write(16'd1001, 8'h99);
    bus.vga_port_local_addr = 16'd1001;
    bus.fill_data  = 8'hC3;
    bus.fill_start = 1'b1;
    step();
    bus.fill_start = 1'b0;
    repeat (1000) step();   // addresses 0..999 written
    checks++; if (bus.vga_port_backgrounddata !== 8'h99) begin errors++; $display("FAIL mid_pre_data: got %02h required 99", bus.vga_port_backgrounddata); end
    Reset = 1'b1;
    #1;
    checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b required 0", bus.fill_busy); end
    checks++; if (bus.vga_port_backgrounddata !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %02h required 00", bus.vga_port_backgrounddata); end
    checks++; if (bus.host_wr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b required 0", bus.host_wr_ready); end
    repeat (2) begin
      step();
      if (bus.fill_done) done_seen++;
    end
    Reset = 1'b0;
    repeat (5) begin
      step();
      if (bus.fill_done) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses required 0", done_seen); end
    checks++; if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL mid_post_busy: got %0b required 0", bus.fill_busy); end
    read_byte(16'd999, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL mid_addr999: got %02h required c3", d); end
    read_byte(16'd1001, d);
    checks++; if (d !== 8'h99) begin errors++; $display("FAIL mid_addr1001: got %02h required 99", d); end
  endtask

  initial begin
    bus.vga_port_local_addr = '0;
    bus.host_wr_valid       = 1'b0;
    bus.host_wr_addr        = '0;
    bus.host_wr_data        = '0;
    bus.fill_start          = 1'b0;
    bus.fill_data           = '0;
    test_reset();
    test_read_latency();
    test_bad_addr();
    test_fill_start();
    test_backpressure();
    test_fill_complete();
    test_fill_vs_drain();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
